// File: rtl/bm_xfer_pkg.sv
// ---------------------------------------------------------------------------
// bm_xfer_pkg
// Shared definitions for the bitmap transfer engine: geometry of a bitmap in
// memory words, command encodings, the legal bitmap-register range and the
// FSM state type.
// ---------------------------------------------------------------------------
package bm_xfer_pkg;

  localparam int W  = 16;     // memory word width
  localparam int B  = 1536;   // bitmap register width
  localparam int N  = B / W;  // words per bitmap (96)
  localparam int AW = 16;     // memory address width
  localparam int CW = 7;      // word counter width, holds 0..N-1

  localparam logic OP_LOAD  = 1'b0;  // memory -> bitmap
  localparam logic OP_STORE = 1'b1;  // bitmap -> memory

  localparam logic [1:0] MAX_BM_SEL = 2'd2;

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_DRAIN,
    LD_WB,
    ST_LATCH,
    ST_WR
  } state_e;

endpackage

// File: rtl/bm_word_buf.sv
// ---------------------------------------------------------------------------
// bm_word_buf
// 96 x 16-bit staging buffer between the memory side (one word at a time) and
// the bitmap side (the whole 1536-bit register at once).
//
// Ports:
//   clk        clock
//   wr_en_i    write one word at wr_idx_i
//   wr_idx_i   word index for the single-word write
//   wr_data_i  word to write
//   ld_en_i    load all words in parallel from ld_data_i (wins over wr_en_i)
//   ld_data_i  full bitmap image, word i in bits [16i+15:16i]
//   rd_idx_i   word index for the single-word read
//   rd_word_o  word at rd_idx_i (zero when the index is past the last word)
//   all_data_o full buffer contents, same layout as ld_data_i
// ---------------------------------------------------------------------------
module bm_word_buf
  import bm_xfer_pkg::*;
(
  input  logic         clk,
  input  logic         wr_en_i,
  input  cnt_t         wr_idx_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         ld_en_i,
  input  logic [B-1:0] ld_data_i,
  input  cnt_t         rd_idx_i,
  output logic [W-1:0] rd_word_o,
  output logic [B-1:0] all_data_o
);

  logic [N-1:0][W-1:0] buf_q;

  // NOTE: the buffer is a data store with no reset on purpose; its contents
  // are meaningless until a transfer fills it, and a reset on 1536 flops buys
  // nothing but routing.
  always_ff @(posedge clk) begin
    if (ld_en_i) begin
      buf_q <= ld_data_i;
    end else if (wr_en_i && (wr_idx_i < cnt_t'(N))) begin
      buf_q[wr_idx_i] <= wr_data_i;
    end
  end

  // The store path looks one word ahead, so the index can reach N on the
  // final word; that lookahead value is never used.
  assign rd_word_o  = (rd_idx_i < cnt_t'(N)) ? buf_q[rd_idx_i] : '0;
  assign all_data_o = buf_q;

endmodule

// File: rtl/bm_xfer.sv
// ---------------------------------------------------------------------------
// bm_xfer
// DMA-style transfer engine between the 16-bit data memory and the three
// 1536-bit bitmap registers.
//   LOAD : read 96 consecutive words (1-cycle read latency), assemble them and
//          commit with a single wbm pulse.
//   STORE: snapshot one bitmap register, then write it out as 96 words.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op, bm_sel,  command strobe (sampled in IDLE only), 0=LOAD/1=STORE,
//   base_addr           bitmap index 0..2, address of word 0
//   busy, done, err     status: not IDLE, completion pulse, rejected command
//   mem_addr, mem_rd,   memory port; read data returns one cycle after mem_rd
//   mem_rdata, mem_wr,
//   mem_wdata
//   rbm_addr, rbm_data  bitmap read port (combinational data)
//   wbm, wbm_addr,      bitmap write port
//   wbm_data
// All outputs are registered except wbm_data, which is the buffer itself.
// ---------------------------------------------------------------------------
module bm_xfer
  import bm_xfer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [1:0]    bm_sel,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [W-1:0]  mem_rdata,
  output logic          mem_wr,
  output logic [W-1:0]  mem_wdata,
  output logic [1:0]    rbm_addr,
  input  logic [B-1:0]  rbm_data,
  output logic          wbm,
  output logic [1:0]    wbm_addr,
  output logic [B-1:0]  wbm_data
);

  localparam cnt_t LAST = cnt_t'(N - 1);

  state_e        state_q;
  cnt_t          cnt_q;
  logic [AW-1:0] base_q;
  logic          busy_q, done_q, err_q;
  logic          mem_rd_q, mem_wr_q, wbm_q;
  logic [AW-1:0] mem_addr_q;
  logic [W-1:0]  mem_wdata_q;
  logic [1:0]    rbm_addr_q, wbm_addr_q;

  cnt_t          cnt_d;
  logic [AW-1:0] addr_d;
  logic          buf_wr_en, buf_ld_en;
  cnt_t          buf_wr_idx;
  logic [W-1:0]  buf_rd_word;

  // NOTE: every signal assigned here gets a value on every path, so this
  // block stays purely combinational and cannot infer a latch.
  always_comb begin
    cnt_d  = cnt_q + cnt_t'(1);
    // Address arithmetic wraps naturally at 2^AW.
    addr_d = base_q + AW'(cnt_d);

    // Read data for word cnt-1 arrives while word cnt is being requested;
    // the last word arrives in LD_DRAIN, after the read strobe has dropped.
    buf_wr_en  = ((state_q == LD_RD) && (cnt_q != '0)) || (state_q == LD_DRAIN);
    buf_wr_idx = (state_q == LD_DRAIN) ? LAST : (cnt_q - cnt_t'(1));
    buf_ld_en  = (state_q == ST_LATCH);
  end

  bm_word_buf u_buf (
    .clk        (clk),
    .wr_en_i    (buf_wr_en),
    .wr_idx_i   (buf_wr_idx),
    .wr_data_i  (mem_rdata),
    .ld_en_i    (buf_ld_en),
    .ld_data_i  (rbm_data),
    .rd_idx_i   (cnt_d),
    .rd_word_o  (buf_rd_word),
    .all_data_o (wbm_data)
  );

  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // updates use non-blocking assignments so every register sees the values
  // from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      wbm_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rbm_addr_q  <= '0;
      wbm_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            if (bm_sel <= MAX_BM_SEL) begin
              base_q     <= base_addr;
              rbm_addr_q <= bm_sel;
              wbm_addr_q <= bm_sel;
              cnt_q      <= '0;
              busy_q     <= 1'b1;
              if (op == OP_LOAD) begin
                state_q    <= LD_RD;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= base_addr;
              end else begin
                state_q <= ST_LATCH;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        LD_RD: begin
          if (cnt_q == LAST) begin
            mem_rd_q <= 1'b0;
            state_q  <= LD_DRAIN;
          end else begin
            cnt_q      <= cnt_d;
            mem_addr_q <= addr_d;
          end
        end

        LD_DRAIN: begin
          wbm_q   <= 1'b1;
          done_q  <= 1'b1;
          state_q <= LD_WB;
        end

        LD_WB: begin
          wbm_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        ST_LATCH: begin
          // The buffer captures rbm_data on this same edge, so word 0 is
          // taken straight from the bitmap port.
          mem_wr_q    <= 1'b1;
          mem_addr_q  <= base_q;
          mem_wdata_q <= rbm_data[W-1:0];
          cnt_q       <= '0;
          state_q     <= ST_WR;
        end

        ST_WR: begin
          if (cnt_q == LAST) begin
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q       <= cnt_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= buf_rd_word;
            // done coincides with the last write.
            if (cnt_q == LAST - cnt_t'(1)) begin
              done_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign rbm_addr  = rbm_addr_q;
  assign wbm       = wbm_q;
  assign wbm_addr  = wbm_addr_q;

endmodule

// File: tb/tb_bm_xfer.sv
// ---------------------------------------------------------------------------
// tb_bm_xfer
// Self-checking bench for bm_xfer. A memory and three bitmap registers model
// the environment; a monitor logs every strobe with its cycle number, and a
// reference model (memory snapshots and a copy of each bitmap) provides the
// expected transfer results. Cycle k is the cycle in which start is high.
// ---------------------------------------------------------------------------
module tb_bm_xfer;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          op;
  logic [1:0]    bm_sel;
  logic [15:0]   base_addr;
  logic          busy, done, err;
  logic [15:0]   mem_addr;
  logic          mem_rd;
  logic [15:0]   mem_rdata = '0;
  logic          mem_wr;
  logic [15:0]   mem_wdata;
  logic [1:0]    rbm_addr;
  logic [1535:0] rbm_data;
  logic          wbm;
  logic [1:0]    wbm_addr;
  logic [1535:0] wbm_data;

  bm_xfer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .bm_sel    (bm_sel),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .rbm_addr  (rbm_addr),
    .rbm_data  (rbm_data),
    .wbm       (wbm),
    .wbm_addr  (wbm_addr),
    .wbm_data  (wbm_data)
  );

  always #5 clk = ~clk;

  // ---------------- environment ----------------
  logic [15:0]   mem     [0:65535];
  logic [1535:0] bm_regs [0:3];
  logic [1535:0] model_bm[0:3];

  assign rbm_data = bm_regs[rbm_addr];

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] = mem_wdata;
    if (wbm)    bm_regs[wbm_addr] = wbm_data;
  end

  // ---------------- monitor ----------------
  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  typedef struct {
    int            cyc;
    logic [1:0]    a;
    logic [1535:0] d;
  } wbm_ev_t;

  int      cyc = 0;
  ev_t     rd_q[$];
  ev_t     wr_q[$];
  wbm_ev_t wbm_q[$];
  int      done_q[$];
  int      err_q[$];
  int      n_overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_rd)           rd_q.push_back('{cyc, mem_addr, 16'h0});
    if (mem_wr)           wr_q.push_back('{cyc, mem_addr, mem_wdata});
    if (wbm)              wbm_q.push_back('{cyc, wbm_addr, wbm_data});
    if (done)             done_q.push_back(cyc);
    if (err)              err_q.push_back(cyc);
    if (mem_rd && mem_wr) n_overlap++;
  end

  // ---------------- checking ----------------
  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [1535:0] last_bm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bm(input string tag, input logic [1535:0] obs, input logic [1535:0] exp);
    int bad;
    bad = 0;
    for (int i = 95; i >= 0; i--) if (obs[16*i +: 16] !== exp[16*i +: 16]) bad = i;
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: word %0d observed 0x%0h expected 0x%0h",
             tag, bad, obs[16*bad +: 16], exp[16*bad +: 16]);
    end
  endtask

  task automatic clear_log();
    rd_q.delete();
    wr_q.delete();
    wbm_q.delete();
    done_q.delete();
    err_q.delete();
    n_overlap = 0;
  endtask

  // Issues one command starting in the current cycle (caller sits at a
  // negedge) and returns at the negedge of the first cycle where a new
  // command must be accepted. poke>0 pulses a STORE start at cycle k+poke.
  task automatic run_cmd(input logic o, input logic [1:0] s, input logic [15:0] b, input int poke);
    int            k, len, last_c, idx;
    bit            legal, ld;
    logic [1535:0] exp_bm;
    logic [63:0]   obs;

    legal = (s <= 2'd2);
    ld    = (o == 1'b0);
    if (ld) for (int i = 0; i < 96; i++) exp_bm[16*i +: 16] = mem[16'(b + i)];
    else    exp_bm = model_bm[s];
    last_c = ld ? 98 : 97;
    len    = legal ? last_c + 1 : 2;

    clear_log();
    start = 1'b1; op = o; bm_sel = s; base_addr = b;
    k = cyc;
    for (int t = 1; t <= len; t++) begin
      @(negedge clk);
      if (t == poke) begin
        start = 1'b1; op = 1'b1; bm_sel = 2'd0;
      end else begin
        start = 1'b0; op = 1'($urandom); bm_sel = 2'($urandom);
      end
      base_addr = 16'($urandom);
      if (t == 1) begin
        chk("busy_first", busy, legal);
        if (legal && !ld) chk("rbm_addr_latch", rbm_addr, s);
      end
      if (legal && t == 50 && !ld) chk("rbm_addr_hold", rbm_addr, s);
      if (legal && t == last_c) chk("busy_last", busy, 1);
      if (t == len) chk("busy_after", busy, 0);
    end

    chk("n_err", err_q.size(), legal ? 0 : 1);
    if (!legal) chk("err_cyc", (err_q.size() > 0) ? err_q[0] : -1, k + 1);

    chk("n_rd", rd_q.size(), (legal && ld) ? 96 : 0);
    if (legal && ld) begin
      idx = 95;
      for (int i = 0; i < 96; i++)
        if (i >= rd_q.size() || rd_q[i].cyc != k + 1 + i || rd_q[i].addr !== 16'(b + i)) begin
          idx = i; break;
        end
      obs = (idx < rd_q.size()) ? {32'(rd_q[idx].cyc), rd_q[idx].addr} : '1;
      chk("rd_seq", obs, {32'(k + 1 + idx), 16'(b + idx)});
    end

    chk("n_wr", wr_q.size(), (legal && !ld) ? 96 : 0);
    if (legal && !ld) begin
      idx = 95;
      for (int i = 0; i < 96; i++)
        if (i >= wr_q.size() || wr_q[i].cyc != k + 2 + i || wr_q[i].addr !== 16'(b + i) ||
            wr_q[i].data !== exp_bm[16*i +: 16]) begin
          idx = i; break;
        end
      obs = (idx < wr_q.size()) ? {16'(wr_q[idx].cyc), wr_q[idx].addr, wr_q[idx].data} : '1;
      chk("wr_seq", obs, {16'(k + 2 + idx), 16'(b + idx), exp_bm[16*idx +: 16]});
    end

    chk("n_wbm", wbm_q.size(), (legal && ld) ? 1 : 0);
    if (legal && ld && wbm_q.size() > 0) begin
      chk("wbm_cyc", wbm_q[0].cyc, k + 98);
      chk("wbm_addr", wbm_q[0].a, s);
      chk_bm("wbm_data", wbm_q[0].d, exp_bm);
      last_bm = wbm_q[0].d;
    end
    if (legal && ld) model_bm[s] = exp_bm;

    chk("n_done", done_q.size(), legal ? 1 : 0);
    if (legal) chk("done_cyc", (done_q.size() > 0) ? done_q[0] : -1, k + last_c);
    chk("rd_wr_excl", n_overlap, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    rst = 1'b1; start = 1'b0; op = 1'b0; bm_sel = 2'd0; base_addr = '0;
    last_bm = '0;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int r = 0; r < 4; r++)
      for (int w = 0; w < 96; w++) bm_regs[r][16*w +: 16] = (r == 3) ? 16'h0 : 16'($urandom);
    for (int i = 0; i < 96; i++) begin
      mem[16'h0100 + i]      = 16'hA000 + 16'(i);
      bm_regs[2][16*i +: 16] = 16'h5500 + 16'(i);
    end
    mem[0] = 16'h0BAD;
    for (int r = 0; r < 4; r++) model_bm[r] = bm_regs[r];

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_wbm", wbm, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rbm_addr", rbm_addr, 0);
    chk("rst_wbm_addr", wbm_addr, 0);

    // LOAD of a known ramp into bitmap 1.
    run_cmd(1'b0, 2'd1, 16'h0100, 0);
    chk("ld_word0", last_bm[15:0], 16'hA000);
    chk("ld_word95", last_bm[1535:1520], 16'hA05F);

    // STORE of bitmap 2 (ramp 0x5500+i), issued in the first IDLE cycle.
    run_cmd(1'b1, 2'd2, 16'h2000, 0);

    // LOAD across the top of the address space.
    run_cmd(1'b0, 2'd0, 16'hFFF0, 0);
    chk("wrap_word16", last_bm[16*16 +: 16], 16'h0BAD);

    // Rejected select.
    run_cmd(1'($urandom), 2'd3, 16'($urandom), 0);

    // Abort a LOAD at k+50; a start coincides with the reset and must lose.
    clear_log();
    start = 1'b1; op = 1'b0; bm_sel = 2'd0; base_addr = 16'h0100;
    k = cyc;
    for (int t = 1; t < 50; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 1'b1; bm_sel = 2'd1;
    @(negedge clk);
    chk("abort_cycle", cyc, k + 51);
    chk("abort_busy", busy, 0);
    chk("abort_rd", mem_rd, 0);
    chk("abort_wr", mem_wr, 0);
    chk("abort_wbm", wbm, 0);
    chk("abort_done", done, 0);
    rst = 1'b0; start = 1'b0;
    repeat (200) @(negedge clk);
    chk("abort_n_wbm", wbm_q.size(), 0);
    chk("abort_n_done", done_q.size(), 0);
    chk("abort_n_wr", wr_q.size(), 0);

    // STORE after the abort: bitmap 1 still holds the ramp from the first LOAD.
    run_cmd(1'b1, 2'd1, 16'h3000, 0);

    // start while busy is ignored.
    run_cmd(1'b0, 2'd2, 16'h4000, 30);

    // Randomized commands, including illegal selects and wrap-around bases.
    for (int n = 0; n < 8; n++)
      run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
